// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM, byte presented on a
// valid/ready interface with one-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned FCLK = 50_000_000,
  parameter int unsigned BAUD = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_idle,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned WcBitI  = FCLK / BAUD - 1;
  localparam int unsigned WcHalfI = FCLK / (2 * BAUD) - 1;
  localparam int unsigned WcW     = $clog2(WcBitI + 1);

  localparam logic [WcW-1:0] WcBit  = WcW'(WcBitI);
  localparam logic [WcW-1:0] WcHalf = WcW'(WcHalfI);

  if (FCLK / BAUD < 16) begin : gen_ratio_check
    $error("uart_rx: FCLK/BAUD must be at least 16");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic [WcW-1:0]   wc_q, wc_d;
  logic             wc_zero;
  logic [2:0]       bc_q, bc_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             rx_idle_q, rx_idle_d;
  logic             byte_done;

  assign rx_s    = sync2_q;
  assign wc_zero = (wc_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      wc_q        <= '0;
      bc_q        <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_idle_q   <= 1'b1;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      wc_q        <= wc_d;
      bc_q        <= bc_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_idle_q   <= rx_idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q - 1'b1;
    bc_d        = bc_q;
    shreg_d     = shreg_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        bc_d = '0;
        if (!rx_s) begin
          state_d = StStart;
          wc_d    = WcHalf;
        end
      end
      StStart: begin
        if (wc_zero) begin
          if (!rx_s) begin
            state_d = StData;
            wc_d    = WcBit;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (wc_zero) begin
          // Line order is LSB first, so each new bit enters at the MSB.
          shreg_d = {rx_s, shreg_q[7:1]};
          bc_d    = bc_q + 3'd1;
          wc_d    = WcBit;
          if (bc_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (wc_zero) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHi;
          end
        end
      end
      StWaitHi: begin
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    rx_idle_d  = (state_d == StIdle);
    if (byte_done) begin
      // A byte arriving while the previous one is still held is dropped.
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_idle   = rx_idle_q;

endmodule
